// File: rtl/stripe_ctrl.sv
// stripe_ctrl: sequences a striped systolic alignment. Each stripe loads N
// query characters into the PE array, feeds q_len reference columns to PE0
// with the previous stripe's boundary values, collects the chosen end PE's
// outputs into a boundary buffer, then clears the array before the next stripe.
// Ports:
//   clk, reset_i                 clock, async active-low reset
//   start, q_len, stripes, last_pe  begin alignment, config sampled on start
//   stall                        freeze column feed (FEED state only)
//   end_valid, end_h/f/fh        outputs of the selected end PE
//   busy, done, err              status; done is a pulse, err is sticky overflow
//   stripe_idx, end_sel          current stripe, end PE routed to end_*
//   s_load, s_load_idx           query-load strobe and target PE
//   t_valid, t_col, h/f/fh_bnd   column feed to PE0
//   pe_clr_n                     active-low PE-array clear between stripes
module stripe_ctrl #(
    parameter int unsigned N          = 4,
    parameter int unsigned CALC_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned SW         = 4,
    parameter logic signed [CALC_WIDTH-1:0] NEG_INF =
        CALC_WIDTH'(-(32'sd1 <<< (CALC_WIDTH - 2))),
    localparam int unsigned LN = (N > 1) ? $clog2(N) : 1
) (
    input  logic                         clk,
    input  logic                         reset_i,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        q_len,
    input  logic [SW-1:0]                stripes,
    input  logic [LN-1:0]                last_pe,
    input  logic                         stall,
    input  logic                         end_valid,
    input  logic signed [CALC_WIDTH-1:0] end_h,
    input  logic signed [CALC_WIDTH-1:0] end_f,
    input  logic signed [CALC_WIDTH-1:0] end_fh,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [SW-1:0]                stripe_idx,
    output logic [LN-1:0]                end_sel,
    output logic                         s_load,
    output logic [LN-1:0]                s_load_idx,
    output logic                         t_valid,
    output logic [ADDR_WIDTH-1:0]        t_col,
    output logic signed [CALC_WIDTH-1:0] h_bnd,
    output logic signed [CALC_WIDTH-1:0] f_bnd,
    output logic signed [CALC_WIDTH-1:0] fh_bnd,
    output logic                         pe_clr_n
);

    localparam int unsigned EW    = 3 * CALC_WIDTH;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, CLEAR} state_e;

    state_e                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]          q_len_q, q_len_d;
    logic [SW-1:0]                  stripes_q, stripes_d;
    logic [LN-1:0]                  last_pe_q, last_pe_d;
    logic [SW-1:0]                  stripe_idx_q, stripe_idx_d;
    logic [LN-1:0]                  ld_cnt_q, ld_cnt_d;
    logic [ADDR_WIDTH-1:0]          col_q, col_d;
    logic [ADDR_WIDTH-1:0]          wr_cnt_q, wr_cnt_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           err_q, err_d;
    logic                           s_load_q, s_load_d;
    logic [LN-1:0]                  s_load_idx_q, s_load_idx_d;
    logic [LN-1:0]                  end_sel_q, end_sel_d;
    logic                           t_valid_q, t_valid_d;
    logic [ADDR_WIDTH-1:0]          t_col_q, t_col_d;
    logic signed [CALC_WIDTH-1:0]   h_bnd_q, h_bnd_d;
    logic signed [CALC_WIDTH-1:0]   f_bnd_q, f_bnd_d;
    logic signed [CALC_WIDTH-1:0]   fh_bnd_q, fh_bnd_d;
    logic                           pe_clr_n_q, pe_clr_n_d;

    logic [EW-1:0]                  bnd_mem [DEPTH];
    logic [EW-1:0]                  rd_word_c;
    logic                           wr_en_c;
    logic                           ovf_c;

    // Boundary buffer: asynchronous read of the next column (prefetch), so a
    // same-cycle write to that address is seen only by the following stripe.
    assign rd_word_c = bnd_mem[col_q];
    assign wr_en_c   = end_valid && (state_q != IDLE) && (wr_cnt_q != q_len_q);
    assign ovf_c     = end_valid && (state_q != IDLE) && (wr_cnt_q == q_len_q);

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            bnd_mem[wr_cnt_q] <= {end_h, end_f, end_fh};
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            q_len_q      <= '0;
            stripes_q    <= '0;
            last_pe_q    <= '0;
            stripe_idx_q <= '0;
            ld_cnt_q     <= '0;
            col_q        <= '0;
            wr_cnt_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            s_load_q     <= 1'b0;
            s_load_idx_q <= '0;
            end_sel_q    <= LN'(N - 1);
            t_valid_q    <= 1'b0;
            t_col_q      <= '0;
            h_bnd_q      <= '0;
            f_bnd_q      <= '0;
            fh_bnd_q     <= '0;
            pe_clr_n_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            q_len_q      <= q_len_d;
            stripes_q    <= stripes_d;
            last_pe_q    <= last_pe_d;
            stripe_idx_q <= stripe_idx_d;
            ld_cnt_q     <= ld_cnt_d;
            col_q        <= col_d;
            wr_cnt_q     <= wr_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            s_load_q     <= s_load_d;
            s_load_idx_q <= s_load_idx_d;
            end_sel_q    <= end_sel_d;
            t_valid_q    <= t_valid_d;
            t_col_q      <= t_col_d;
            h_bnd_q      <= h_bnd_d;
            f_bnd_q      <= f_bnd_d;
            fh_bnd_q     <= fh_bnd_d;
            pe_clr_n_q   <= pe_clr_n_d;
        end
    end

    // Next-state and next-output logic; outputs derive from the next state so
    // they line up with the state they describe.
    always_comb begin
        state_d      = state_q;
        q_len_d      = q_len_q;
        stripes_d    = stripes_q;
        last_pe_d    = last_pe_q;
        stripe_idx_d = stripe_idx_q;
        ld_cnt_d     = ld_cnt_q;
        col_d        = col_q;
        wr_cnt_d     = wr_cnt_q;
        err_d        = err_q;
        done_d       = 1'b0;
        t_valid_d    = 1'b0;
        t_col_d      = t_col_q;
        h_bnd_d      = h_bnd_q;
        f_bnd_d      = f_bnd_q;
        fh_bnd_d     = fh_bnd_q;

        if (wr_en_c) begin
            wr_cnt_d = wr_cnt_q + ADDR_WIDTH'(1);
        end
        if (ovf_c) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if ((q_len != '0) && (stripes != '0)) begin
                        q_len_d      = q_len;
                        stripes_d    = stripes;
                        last_pe_d    = last_pe;
                        stripe_idx_d = '0;
                        ld_cnt_d     = '0;
                        wr_cnt_d     = '0;
                        state_d      = LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (ld_cnt_q == LN'(N - 1)) begin
                    col_d   = '0;
                    state_d = FEED;
                end else begin
                    ld_cnt_d = ld_cnt_q + LN'(1);
                end
            end
            FEED: begin
                if (!stall) begin
                    t_valid_d = 1'b1;
                    t_col_d   = col_q;
                    col_d     = col_q + ADDR_WIDTH'(1);
                    if (stripe_idx_q == '0) begin
                        h_bnd_d  = '0;
                        f_bnd_d  = NEG_INF;
                        fh_bnd_d = NEG_INF;
                    end else begin
                        {h_bnd_d, f_bnd_d, fh_bnd_d} = rd_word_c;
                    end
                    if (col_q == q_len_q - ADDR_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (wr_cnt_q == q_len_q) begin
                    if (stripe_idx_q == stripes_q - SW'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stripe_idx_d = stripe_idx_q + SW'(1);
                        state_d      = CLEAR;
                    end
                end
            end
            CLEAR: begin
                ld_cnt_d = '0;
                wr_cnt_d = '0;
                state_d  = LOAD;
            end
            default: state_d = IDLE;
        endcase

        busy_d       = (state_d != IDLE);
        s_load_d     = (state_d == LOAD);
        s_load_idx_d = s_load_d ? ld_cnt_d : '0;
        pe_clr_n_d   = (state_d != CLEAR);
        // The final stripe may end at a PE other than N-1.
        end_sel_d    = ((state_d != IDLE) && (stripe_idx_d == stripes_d - SW'(1)))
                       ? last_pe_d : LN'(N - 1);
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign stripe_idx = stripe_idx_q;
    assign end_sel    = end_sel_q;
    assign s_load     = s_load_q;
    assign s_load_idx = s_load_idx_q;
    assign t_valid    = t_valid_q;
    assign t_col      = t_col_q;
    assign h_bnd      = h_bnd_q;
    assign f_bnd      = f_bnd_q;
    assign fh_bnd     = fh_bnd_q;
    assign pe_clr_n   = pe_clr_n_q;

endmodule

// File: tb/tb_stripe_ctrl.sv
// Directed testbench for stripe_ctrl (default parameters: N=4, 16-bit scores).
module tb_stripe_ctrl;

    localparam int CW = 16;
    localparam int AW = 10;
    localparam logic signed [CW-1:0] NINF = -16'sd16384;

    logic clk = 1'b0;
    logic reset_i;
    logic start;
    logic [AW-1:0] q_len;
    logic [3:0] stripes;
    logic [1:0] last_pe;
    logic stall;
    logic end_valid;
    logic signed [CW-1:0] end_h, end_f, end_fh;
    logic busy, done, err;
    logic [3:0] stripe_idx;
    logic [1:0] end_sel;
    logic s_load;
    logic [1:0] s_load_idx;
    logic t_valid;
    logic [AW-1:0] t_col;
    logic signed [CW-1:0] h_bnd, f_bnd, fh_bnd;
    logic pe_clr_n;

    int checks = 0;
    int failures = 0;

    int cap_n;
    logic [AW-1:0] cap_col [8];
    logic signed [CW-1:0] cap_h [8];
    logic signed [CW-1:0] cap_f [8];
    logic signed [CW-1:0] cap_fh [8];

    stripe_ctrl dut (
        .clk(clk), .reset_i(reset_i), .start(start), .q_len(q_len),
        .stripes(stripes), .last_pe(last_pe), .stall(stall),
        .end_valid(end_valid), .end_h(end_h), .end_f(end_f), .end_fh(end_fh),
        .busy(busy), .done(done), .err(err), .stripe_idx(stripe_idx),
        .end_sel(end_sel), .s_load(s_load), .s_load_idx(s_load_idx),
        .t_valid(t_valid), .t_col(t_col), .h_bnd(h_bnd), .f_bnd(f_bnd),
        .fh_bnd(fh_bnd), .pe_clr_n(pe_clr_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] ql, input logic [3:0] st, input logic [1:0] lp);
        start = 1'b1; q_len = ql; stripes = st; last_pe = lp;
        tick();
        start = 1'b0;
    endtask

    task automatic send_end(input int h, input int f, input int fh);
        end_valid = 1'b1; end_h = CW'(h); end_f = CW'(f); end_fh = CW'(fh);
        tick();
        end_valid = 1'b0;
    endtask

    task automatic capture_feed(input int n_exp);
        int b = 0;
        cap_n = 0;
        while (cap_n < n_exp && b < 60) begin
            if (t_valid) begin
                cap_col[cap_n] = t_col; cap_h[cap_n] = h_bnd;
                cap_f[cap_n] = f_bnd; cap_fh[cap_n] = fh_bnd;
                cap_n++;
            end
            if (cap_n < n_exp) tick();
            b++;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int b = 0; b < 40; b++) begin
            if (done) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_col(input logic [AW-1:0] c, output bit ok);
        ok = 1'b0;
        for (int b = 0; b < 40; b++) begin
            if (t_valid && t_col == c) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1; start = 0; q_len = 0; stripes = 0; last_pe = 0;
        stall = 0; end_valid = 0; end_h = 0; end_f = 0; end_fh = 0;
        #1 reset_i = 1'b0;
        #11;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_done_err got=%b%b exp=00", done, err); end
        checks++; if (pe_clr_n !== 1'b1) begin failures++; $display("FAIL reset_pe_clr_n got=%b exp=1", pe_clr_n); end
        checks++; if (end_sel !== 2'd3) begin failures++; $display("FAIL reset_end_sel got=%0d exp=3", end_sel); end
        checks++; if (s_load !== 1'b0 || t_valid !== 1'b0 || t_col !== '0 || stripe_idx !== '0)
            begin failures++; $display("FAIL reset_strobes got=%b%b col=%0d stripe=%0d exp=00 0 0", s_load, t_valid, t_col, stripe_idx); end
        reset_i = 1'b1;
        tick();
    endtask

    task automatic test_single_stripe();
        bit ok;
        do_start(3, 1, 2);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
        checks++; if (end_sel !== 2'd2) begin failures++; $display("FAIL single_end_sel got=%0d exp=2", end_sel); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (s_load !== 1'b1 || s_load_idx !== 2'(i))
                begin failures++; $display("FAIL load_%0d got=%b/%0d exp=1/%0d", i, s_load, s_load_idx, i); end
            tick();
        end
        checks++; if (s_load !== 1'b0) begin failures++; $display("FAIL load_end got=%b exp=0", s_load); end
        capture_feed(3);
        checks++; if (cap_n !== 3) begin failures++; $display("FAIL single_cols got=%0d exp=3", cap_n); end
        for (int i = 0; i < cap_n; i++) begin
            checks++; if (cap_col[i] !== AW'(i) || cap_h[i] !== 16'sd0 || cap_f[i] !== NINF || cap_fh[i] !== NINF)
                begin failures++; $display("FAIL single_col%0d got=%0d h=%0d f=%0d fh=%0d exp=%0d 0 %0d %0d", i, cap_col[i], cap_h[i], cap_f[i], cap_fh[i], i, NINF, NINF); end
        end
        send_end(1, 2, 3); send_end(4, 5, 6); send_end(7, 8, 9);
        wait_done(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_done got=timeout exp=done"); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_done got=%b exp=0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_two_stripes();
        bit ok;
        int eh[3] = '{5, 7, 9};
        int ef[3] = '{-1, -2, -3};
        int efh[3] = '{10, 11, 12};
        do_start(3, 2, 1);
        checks++; if (end_sel !== 2'd3) begin failures++; $display("FAIL two_end_sel0 got=%0d exp=3", end_sel); end
        capture_feed(3);
        checks++; if (cap_n !== 3) begin failures++; $display("FAIL two_cols0 got=%0d exp=3", cap_n); end
        for (int i = 0; i < 3; i++) send_end(eh[i], ef[i], efh[i]);
        send_end(99, 99, 99);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL two_overflow_err got=%b exp=1", err); end
        checks++; if (pe_clr_n !== 1'b0 || stripe_idx !== 4'd1)
            begin failures++; $display("FAIL two_clear got=%b/%0d exp=0/1", pe_clr_n, stripe_idx); end
        checks++; if (end_sel !== 2'd1) begin failures++; $display("FAIL two_end_sel1 got=%0d exp=1", end_sel); end
        tick();
        checks++; if (pe_clr_n !== 1'b1 || s_load !== 1'b1)
            begin failures++; $display("FAIL two_clear_len got=%b/%b exp=1/1", pe_clr_n, s_load); end
        capture_feed(3);
        checks++; if (cap_n !== 3) begin failures++; $display("FAIL two_cols1 got=%0d exp=3", cap_n); end
        for (int i = 0; i < cap_n; i++) begin
            checks++; if (cap_col[i] !== AW'(i) || cap_h[i] !== CW'(eh[i]) || cap_f[i] !== CW'(ef[i]) || cap_fh[i] !== CW'(efh[i]))
                begin failures++; $display("FAIL two_bnd%0d got=%0d h=%0d f=%0d fh=%0d exp=%0d %0d %0d %0d", i, cap_col[i], cap_h[i], cap_f[i], cap_fh[i], i, eh[i], ef[i], efh[i]); end
        end
        send_end(20, 21, 22); send_end(23, 24, 25); send_end(26, 27, 28);
        wait_done(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL two_done got=timeout exp=done"); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL two_err_sticky got=%b exp=1", err); end
        tick();
    endtask

    task automatic test_zero_len();
        do_start(0, 1, 0);
        checks++; if (done !== 1'b1 || busy !== 1'b0 || s_load !== 1'b0)
            begin failures++; $display("FAIL zero_done got=%b%b%b exp=100", done, busy, s_load); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL zero_err_clear got=%b exp=0", err); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || s_load !== 1'b0)
            begin failures++; $display("FAIL zero_after got=%b%b%b exp=000", done, busy, s_load); end
        do_start(2, 0, 0);
        checks++; if (done !== 1'b1 || busy !== 1'b0)
            begin failures++; $display("FAIL zero_stripes got=%b%b exp=10", done, busy); end
        tick();
    endtask

    task automatic test_stall();
        bit ok;
        do_start(3, 1, 3);
        wait_col(1, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL stall_reach got=timeout exp=col1"); end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (t_valid !== 1'b0 || t_col !== 10'd1 || h_bnd !== 16'sd0 || f_bnd !== NINF)
                begin failures++; $display("FAIL stall_hold%0d got=%b col=%0d h=%0d f=%0d exp=0 1 0 %0d", i, t_valid, t_col, h_bnd, f_bnd, NINF); end
        end
        stall = 1'b0;
        tick();
        checks++; if (t_valid !== 1'b1 || t_col !== 10'd2)
            begin failures++; $display("FAIL stall_release got=%b col=%0d exp=1 2", t_valid, t_col); end
        send_end(1, 1, 1); send_end(2, 2, 2); send_end(3, 3, 3);
        wait_done(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL stall_done got=timeout exp=done"); end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_start(3, 2, 2);
        wait_col(0, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mid_reach got=timeout exp=col0"); end
        reset_i = 1'b0;
        #2;
        checks++; if (busy !== 1'b0 || t_valid !== 1'b0 || s_load !== 1'b0 || done !== 1'b0)
            begin failures++; $display("FAIL mid_status got=%b%b%b%b exp=0000", busy, t_valid, s_load, done); end
        checks++; if (h_bnd !== '0 || f_bnd !== '0 || fh_bnd !== '0 || t_col !== '0)
            begin failures++; $display("FAIL mid_bnd got=%0d %0d %0d col=%0d exp=0 0 0 0", h_bnd, f_bnd, fh_bnd, t_col); end
        checks++; if (pe_clr_n !== 1'b1 || end_sel !== 2'd3 || stripe_idx !== '0)
            begin failures++; $display("FAIL mid_misc got=%b/%0d/%0d exp=1/3/0", pe_clr_n, end_sel, stripe_idx); end
        reset_i = 1'b1;
        tick();
        do_start(2, 1, 0);
        checks++; if (end_sel !== 2'd0) begin failures++; $display("FAIL mid_end_sel got=%0d exp=0", end_sel); end
        capture_feed(2);
        checks++; if (cap_n !== 2 || cap_col[0] !== 10'd0 || cap_col[1] !== 10'd1 || cap_h[1] !== 16'sd0)
            begin failures++; $display("FAIL mid_feed got=n%0d c0=%0d c1=%0d h=%0d exp=n2 0 1 0", cap_n, cap_col[0], cap_col[1], cap_h[1]); end
        send_end(4, 4, 4); send_end(5, 5, 5);
        wait_done(ok);
        checks++; if (ok !== 1'b1 || busy !== 1'b0)
            begin failures++; $display("FAIL mid_done got=%b/%b exp=1/0", ok, busy); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_stripe();
        test_two_stripes();
        test_zero_len();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
